multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Multicycle RV32I control FSM that drives the ALU and shared datapath: produces alu_ctrl and the mux/enable selects, and consumes ZF.
// - Sits between the instruction register (opcode/funct fields) and the datapath.
// - Sequences FETCH/DECODE/EXECUTE/MEM/WB for lw, sw, R-type, I-ALU, jal, beq and bne.
// PARAMETERS
// - STATE_W  4  state register width (11 states used)
// PORTS
// - clk         in   1  rising-edge clock
// - rst_n       in   1  async active-low reset
// - opcode      in   7  instr[6:0] from IR
// - funct3      in   3  instr[14:12]
// - funct7_5    in   1  instr[30]
// - zero        in   1  ALU ZF (combinational, same cycle)
// - pc_write    out  1  PC load enable
// - adr_src     out  1  memory address: 0=PC, 1=ALUOut
// - mem_write   out  1  data memory write enable
// - ir_write    out  1  IR/OldPC load enable
// - reg_write   out  1  register file write enable
// - result_src  out  2  00=ALUOut, 01=mem data, 10=alu_result direct
// - alu_src_a   out  2  00=PC, 01=OldPC, 10=rs1
// - alu_src_b   out  2  00=rs2, 01=imm, 10=const 4
// - imm_src     out  2  00=I, 01=S, 10=B, 11=J (combinational from opcode)
// - alu_ctrl    out  5  ALU op: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 slt, 00110 srl, 00111 sra, 01000 xor
// - illegal     out  1  one-cycle pulse in DECODE or BRANCH on unsupported encoding
// - state_dbg   out  4  current state, for debug/verification
// BEHAVIOUR
// - Reset (async, rst_n=0): state=FETCH immediately. Outputs show the FETCH decode while reset is held; datapath is also held in reset.
// - Moore outputs decoded from state. Exception: pc_write in BRANCH depends on zero (Mealy).
// - Unlisted outputs are 0 in each state. alu_ctrl defaults to add.
// - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, add, result_src=10, pc_write=1 -> DECODE.
// - DECODE: src_a=01, src_b=01, add (branch/jal target into ALUOut). Next state by opcode:
//   - 0000011 / 0100011 -> MEMADR
//   - 0110011 -> EXECR
//   - 0010011 -> EXECI
//   - 1101111 -> JAL
//   - 1100011 -> BRANCH
//   - other -> FETCH, illegal=1
// - MEMADR: src_a=10, src_b=01, add. -> MEMREAD if opcode[5]=0, else MEMWRITE.
// - MEMREAD: adr_src=1, result_src=00 -> MEMWB.
// - MEMWB: result_src=01, reg_write=1 -> FETCH.
// - MEMWRITE: adr_src=1, result_src=00, mem_write=1 -> FETCH.
// - EXECR: src_a=10, src_b=00, alu_ctrl=R-decode -> ALUWB.
// - EXECI: src_a=10, src_b=01, alu_ctrl=I-decode -> ALUWB.
// - ALUWB: result_src=00, reg_write=1 -> FETCH.
// - JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1 -> ALUWB (rd=PC+4).
// - BRANCH: src_a=10, src_b=00, sub, result_src=00. -> FETCH.
//   - funct3=000: pc_write=zero.
//   - funct3=001: pc_write=~zero.
//   - other funct3: pc_write=0, illegal=1.
// - R-decode by funct3:
//   - 000: funct7_5 ? sub : add
//   - 001: sll
//   - 010, 011: slt
//   - 100: xor
//   - 101: funct7_5 ? sra : srl
//   - 110: or
//   - 111: and
// - I-decode: same as R-decode, except funct3=000 is always add.
// - Latency, FETCH to FETCH: lw 5, sw 4, R/I 4, jal 4, branch 3 cycles.
// - No stall input. The FSM never holds a state for more than one cycle.
// - Unreachable state encodings -> FETCH on next clock.
// - Reset mid-instruction: abandons the instruction with no further writes. First cycle after release is FETCH.
// STRUCTURE
// - Package riscv_ctrl_pkg: opcode constants, ALU_* codes, state enum (FETCH..BRANCH), SRC_A/SRC_B/RESULT/IMM select codes.
// - Sub-module alu_decoder: combinational {state-class, funct3, funct7_5} -> alu_ctrl. Reusable by a future pipelined core.
// - Top: state register (async clear) plus next-state and output decode.
// TESTING
// - Reset mid-op: rst_n=0 during MEMREAD of lw -> state_dbg=FETCH at once. After release: ir_write=1, pc_write=1; no reg_write or mem_write before the next FETCH.
// - lw (opcode 0000011): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB. reg_write=1 only in cycle 5 with result_src=01. imm_src=00.
// - R-type, funct3=000: funct7_5=1 -> alu_ctrl=00001 in EXECR; funct7_5=0 -> 00000. reg_write in cycle 4.
// - I-type srai (funct3=101, funct7_5=1) -> alu_ctrl=00111. addi with funct7_5=1 -> 00000.
// - beq, zero=1 -> pc_write=1 in BRANCH; zero=0 -> 0. bne inverts both. Back to FETCH after 3 cycles.
// - opcode 0000000 -> illegal=1 for one cycle in DECODE, next state FETCH, no writes. Branch with funct3=100 -> illegal=1 in BRANCH, pc_write=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes, ALU op
// codes, FSM state encoding, datapath select codes and the immediate-format
// helper. Imported by the interface, the ALU decoder and the top.
package riscv_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SLT = 5'b00101;
    localparam logic [4:0] ALU_SRL = 5'b00110;
    localparam logic [4:0] ALU_SRA = 5'b00111;
    localparam logic [4:0] ALU_XOR = 5'b01000;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC  = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_MEM    = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_e;

    // What the ALU should do in a given state: fixed add/sub, or decoded
    // from funct fields with R-type or I-type rules.
    typedef enum logic [1:0] {
        ALU_CLASS_ADD = 2'b00,
        ALU_CLASS_SUB = 2'b01,
        ALU_CLASS_R   = 2'b10,
        ALU_CLASS_I   = 2'b11
    } alu_class_e;

    // Unsupported opcodes fall back to I-format; nothing consumes the
    // immediate for them since the FSM returns to FETCH.
    function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the instruction register / datapath and the
// multicycle controller.
//   master : controller side (reads IR fields and ZF, drives selects)
//   slave  : datapath side (drives IR fields and ZF, reads selects)
interface multicycle_ctrl_if;

    logic [6:0]                        opcode;
    logic [2:0]                        funct3;
    logic                              funct7_5;
    logic                              zero;

    logic                              pc_write;
    logic                              adr_src;
    logic                              mem_write;
    logic                              ir_write;
    logic                              reg_write;
    logic [1:0]                        result_src;
    logic [1:0]                        alu_src_a;
    logic [1:0]                        alu_src_b;
    logic [1:0]                        imm_src;
    logic [4:0]                        alu_ctrl;
    logic                              illegal;
    logic [riscv_ctrl_pkg::STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
               illegal, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl,
               illegal, state_dbg
    );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder.
//   alu_class : fixed add/sub or R/I-type decode
//   funct3    : instr[14:12]
//   funct7_5  : instr[30]
//   alu_ctrl  : ALU operation code
// Kept free of FSM state so a pipelined core can reuse it.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_class_e  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic [4:0]  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_class)
            ALU_CLASS_ADD: alu_ctrl = ALU_ADD;
            ALU_CLASS_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    // addi has no sub form; instr[30] is immediate data there.
                    3'b000:  alu_ctrl = (alu_class == ALU_CLASS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010,
                    3'b011:  alu_ctrl = ALU_SLT;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Sequences lw, sw, R-type, I-ALU, jal, beq
// and bne through the shared datapath.
//   clk   : rising-edge clock
//   rst_n : async active-low reset, forces FETCH
//   bus   : controller side of multicycle_ctrl_if (IR fields and ZF in,
//           datapath selects, alu_ctrl, illegal and state_dbg out)
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | read regs, ALUOut <= OldPC+imm (branch/jal target)
// MEMADR   | ALUOut <= rs1+imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= mem data
// MEMWRITE | write data memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// JAL      | PC <= ALUOut (target), ALUOut <= OldPC+4
// BRANCH   | compare rs1-rs2, PC <= ALUOut if taken
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_e     state_q, state_d;
    alu_class_e alu_class;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic       opcode_ok;

    always_comb begin
        case (bus.opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_JAL, OP_BRANCH: opcode_ok = 1'b1;
            default: opcode_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_IALU:           state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011).
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RESULT_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_class  = ALU_CLASS_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RESULT_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                illegal   = ~opcode_ok;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RESULT_ALUOUT;
            end
            S_MEMWB: begin
                result_src = RESULT_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RESULT_ALUOUT;
                mem_write  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_class = ALU_CLASS_R;
            end
            S_EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_class = ALU_CLASS_I;
            end
            S_ALUWB: begin
                result_src = RESULT_ALUOUT;
                reg_write  = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RESULT_ALUOUT;
                pc_write   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_class  = ALU_CLASS_SUB;
                result_src = RESULT_ALUOUT;
                // Only place pc_write follows a same-cycle input (ZF).
                case (bus.funct3)
                    3'b000:  pc_write = bus.zero;
                    3'b001:  pc_write = ~bus.zero;
                    default: illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct3    (bus.funct3),
        .funct7_5  (bus.funct7_5),
        .alu_ctrl  (bus.alu_ctrl)
    );

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.imm_src    = imm_src_for(bus.opcode);
    assign bus.illegal    = illegal;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected
// per-cycle outputs, a monitor pops and compares them on each falling edge.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] imm_src;
        logic [4:0] alu;
        logic       illegal;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic [1:0] exp_imm;

    // Hand-written output table per state; alu, pc_write and illegal are
    // supplied by each vector since they depend on the instruction.
    function automatic obs_t expect_for(state_e st, logic [4:0] alu, logic pcw, logic ill);
        obs_t o;
        o = '0;
        o.st = st;
        o.alu = alu;
        o.pc_write = pcw;
        o.illegal = ill;
        o.imm_src = exp_imm;
        case (st)
            S_FETCH:    begin o.ir_write = 1; o.src_a = 2'b00; o.src_b = 2'b10; o.result_src = 2'b10; end
            S_DECODE:   begin o.src_a = 2'b01; o.src_b = 2'b01; end
            S_MEMADR:   begin o.src_a = 2'b10; o.src_b = 2'b01; end
            S_MEMREAD:  begin o.adr_src = 1; end
            S_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1; end
            S_MEMWRITE: begin o.adr_src = 1; o.mem_write = 1; end
            S_EXECR:    begin o.src_a = 2'b10; o.src_b = 2'b00; end
            S_EXECI:    begin o.src_a = 2'b10; o.src_b = 2'b01; end
            S_ALUWB:    begin o.reg_write = 1; end
            S_JAL:      begin o.src_a = 2'b01; o.src_b = 2'b10; end
            S_BRANCH:   begin o.src_a = 2'b10; o.src_b = 2'b00; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state_dbg;
        o.pc_write = bus.pc_write;
        o.adr_src = bus.adr_src;
        o.mem_write = bus.mem_write;
        o.ir_write = bus.ir_write;
        o.reg_write = bus.reg_write;
        o.result_src = bus.result_src;
        o.src_a = bus.alu_src_a;
        o.src_b = bus.alu_src_b;
        o.imm_src = bus.imm_src;
        o.alu = bus.alu_ctrl;
        o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endfunction

    task automatic push_exp(string tag, state_e st, logic [4:0] alu, logic pcw, logic ill);
        exp_q.push_back(expect_for(st, alu, pcw, ill));
        tag_q.push_back(tag);
    endtask

    task automatic cyc(string tag, state_e st, logic [4:0] alu, logic pcw, logic ill);
        push_exp(tag, st, alu, pcw, ill);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic [1:0] imm);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7_5 = f7;
        bus.zero = z;
        exp_imm = imm;
    endtask

    // Monitor: one comparison per cycle that has a pending expectation.
    initial begin
        obs_t  e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = sample();
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL %s: got %h expected %h (state got %0d exp %0d, alu got %b exp %b)",
                              t, a, e, a.st, e.st, a.alu, e.alu);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // R/I ALU vector: FETCH, DECODE, EXEC, ALUWB
    task automatic alu_instr(string tag, logic [6:0] op, logic [2:0] f3, logic f7, logic [4:0] alu_exp);
        set_instr(op, f3, f7, 1'b0, 2'b00);
        cyc({tag, "_fetch"},  S_FETCH,  5'b00000, 1, 0);
        cyc({tag, "_decode"}, S_DECODE, 5'b00000, 0, 0);
        cyc({tag, "_exec"},   (op == 7'b0110011) ? S_EXECR : S_EXECI, alu_exp, 0, 0);
        cyc({tag, "_wb"},     S_ALUWB,  5'b00000, 0, 0);
    endtask

    task automatic br_instr(string tag, logic [2:0] f3, logic z, logic pcw_exp, logic ill_exp);
        set_instr(7'b1100011, f3, 1'b0, z, 2'b10);
        cyc({tag, "_fetch"},  S_FETCH,  5'b00000, 1, 0);
        cyc({tag, "_decode"}, S_DECODE, 5'b00000, 0, 0);
        cyc({tag, "_branch"}, S_BRANCH, 5'b00001, pcw_exp, ill_exp);
    endtask

    initial begin
        rst_n = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 2'b00);
        #2 rst_n = 1'b0;
        #1 chk("reset_state", 32'(bus.state_dbg), 32'd0);
        @(posedge clk); #1;
        cyc("reset_hold", S_FETCH, 5'b00000, 1, 0);
        rst_n = 1'b1;

        // lw
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00);
        cyc("lw_fetch",   S_FETCH,   5'b00000, 1, 0);
        cyc("lw_decode",  S_DECODE,  5'b00000, 0, 0);
        cyc("lw_memadr",  S_MEMADR,  5'b00000, 0, 0);
        cyc("lw_memread", S_MEMREAD, 5'b00000, 0, 0);
        cyc("lw_memwb",   S_MEMWB,   5'b00000, 0, 0);

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01);
        cyc("sw_fetch",    S_FETCH,    5'b00000, 1, 0);
        cyc("sw_decode",   S_DECODE,   5'b00000, 0, 0);
        cyc("sw_memadr",   S_MEMADR,   5'b00000, 0, 0);
        cyc("sw_memwrite", S_MEMWRITE, 5'b00000, 0, 0);

        // R-type
        alu_instr("r_add",  7'b0110011, 3'b000, 1'b0, 5'b00000);
        alu_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 5'b00001);
        alu_instr("r_sra",  7'b0110011, 3'b101, 1'b1, 5'b00111);
        alu_instr("r_or",   7'b0110011, 3'b110, 1'b0, 5'b00011);
        alu_instr("r_sltu", 7'b0110011, 3'b011, 1'b0, 5'b00101);

        // I-type
        alu_instr("i_srai", 7'b0010011, 3'b101, 1'b1, 5'b00111);
        alu_instr("i_addi", 7'b0010011, 3'b000, 1'b1, 5'b00000);
        alu_instr("i_xori", 7'b0010011, 3'b100, 1'b0, 5'b01000);
        alu_instr("i_srli", 7'b0010011, 3'b101, 1'b0, 5'b00110);
        alu_instr("i_andi", 7'b0010011, 3'b111, 1'b0, 5'b00010);
        alu_instr("i_slli", 7'b0010011, 3'b001, 1'b0, 5'b00100);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11);
        cyc("jal_fetch",  S_FETCH,  5'b00000, 1, 0);
        cyc("jal_decode", S_DECODE, 5'b00000, 0, 0);
        cyc("jal_jal",    S_JAL,    5'b00000, 1, 0);
        cyc("jal_wb",     S_ALUWB,  5'b00000, 0, 0);

        // branches
        br_instr("beq_taken",  3'b000, 1'b1, 1'b1, 1'b0);
        br_instr("beq_not",    3'b000, 1'b0, 1'b0, 1'b0);
        br_instr("bne_not",    3'b001, 1'b1, 1'b0, 1'b0);
        br_instr("bne_taken",  3'b001, 1'b0, 1'b1, 1'b0);
        br_instr("br_illegal", 3'b100, 1'b1, 1'b0, 1'b1);

        // illegal opcode: DECODE pulses illegal then straight back to FETCH
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 2'b00);
        cyc("ill_fetch",  S_FETCH,  5'b00000, 1, 0);
        cyc("ill_decode", S_DECODE, 5'b00000, 0, 1);

        // reset in MEMREAD of a lw
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00);
        cyc("rlw_fetch",  S_FETCH,  5'b00000, 1, 0);
        cyc("rlw_decode", S_DECODE, 5'b00000, 0, 0);
        cyc("rlw_memadr", S_MEMADR, 5'b00000, 0, 0);
        push_exp("rlw_memread", S_MEMREAD, 5'b00000, 0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_state",     32'(bus.state_dbg), 32'd0);
        chk("rst_mid_ir_write",  32'(bus.ir_write),  32'd1);
        chk("rst_mid_pc_write",  32'(bus.pc_write),  32'd1);
        chk("rst_mid_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_mid_mem_write", 32'(bus.mem_write), 32'd0);
        @(posedge clk); #1;
        chk("rst_held_state", 32'(bus.state_dbg), 32'd0);
        rst_n = 1'b1;
        alu_instr("post_rst_add", 7'b0110011, 3'b000, 1'b0, 5'b00000);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
